// File: rtl/ahb2apb_bus_arb_pkg.sv
// ahb2apb_bus_arb_pkg: constants and helpers for the bridge's AHB bus arbiter.
// Revision: 1.0
`default_nettype none

package ahb2apb_bus_arb_pkg;

  localparam int TENURE_W    = 8;
  localparam int MAX_MASTERS = 8;

  function automatic logic [TENURE_W-1:0] sat_inc(
    input logic [TENURE_W-1:0] value,
    input logic [TENURE_W-1:0] limit
  );
    return (value >= limit) ? value : value + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_names_pkg.sv
// ahb_names_pkg: shared AHB signal encodings used across the ahb2apb bridge.
`default_nettype none

package ahb_names_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

endpackage

`default_nettype wire

// File: rtl/ahb2apb_bus_arb_rr_pick.sv
// rr_pick: combinational round-robin selector; searches last+1, last+2, ...
// modulo N with last itself checked final.
`default_nettype none

module rr_pick #(
  parameter int N = 4,
  localparam int MIDX = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [MIDX-1:0] last,
  output logic [MIDX-1:0] next_idx,
  output logic            valid
);

  int cand;

  always_comb begin
    next_idx = '0;
    valid    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last) + k;
      if (cand >= N) cand = cand - N;
      if (!valid && req[MIDX'(cand)]) begin
        valid    = 1'b1;
        next_idx = MIDX'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb2apb_bus_arb.sv
// ahb2apb_bus_arb: round-robin AHB arbiter with tenure limit and lock support
// in front of the ahb2apb bridge slave port.
`default_nettype none

module ahb2apb_bus_arb
  import ahb_names_pkg::*;
  import ahb2apb_bus_arb_pkg::*;
#(
  parameter int NMASTER    = 4,
  parameter int MAX_TENURE = 16,
  localparam int MIDX = $clog2(NMASTER)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NMASTER-1:0] hbusreq,
  input  logic [NMASTER-1:0] hlock,
  input  logic [1:0]         htrans,
  input  logic               hready,
  output logic [NMASTER-1:0] hgrant,
  output logic [MIDX-1:0]    hmaster,
  output logic               hmastlock
);

  logic [MIDX-1:0]     gnt_idx;
  logic [MIDX-1:0]     new_gnt;
  logic [MIDX-1:0]     pick_idx;
  logic                pick_valid;
  logic [TENURE_W-1:0] tenure;
  logic                expired;
  logic                other_req;
  logic                ap;

  rr_pick #(.N(NMASTER)) u_rr_pick (
    .req      (hbusreq),
    .last     (gnt_idx),
    .next_idx (pick_idx),
    .valid    (pick_valid)
  );

  always_comb begin
    hgrant          = '0;
    hgrant[gnt_idx] = 1'b1;
  end

  assign other_req = |(hbusreq & ~hgrant);
  assign expired   = (tenure == TENURE_W'(MAX_TENURE));

  // A burst is never broken in the middle of its SEQ beats, even when expired.
  always_comb begin
    ap = hready && !hlock[gnt_idx] &&
         (!hbusreq[gnt_idx] || (htrans == HTRANS_IDLE) ||
          (expired && (htrans != HTRANS_SEQ)));
    new_gnt = gnt_idx;
    if (ap) new_gnt = pick_valid ? pick_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_idx   <= '0;
      tenure    <= '0;
      hmaster   <= '0;
      hmastlock <= 1'b0;
    end else if (hready) begin
      gnt_idx   <= new_gnt;
      hmaster   <= gnt_idx;
      hmastlock <= hlock[gnt_idx];
      if (new_gnt != gnt_idx)
        tenure <= '0;
      else if (other_req)
        tenure <= sat_inc(tenure, TENURE_W'(MAX_TENURE));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb2apb_bus_arb.sv
// tb_ahb2apb_bus_arb: directed scoreboard bench for the AHB bus arbiter
// (NMASTER=4, MAX_TENURE=4).
`default_nettype none

module tb_ahb2apb_bus_arb;
  import ahb_names_pkg::*;

  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] hbusreq = 4'b1111;
  logic [3:0] hlock = 4'b0000;
  logic [1:0] htrans = HTRANS_IDLE;
  logic       hready = 1'b1;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  ahb2apb_bus_arb #(.NMASTER(4), .MAX_TENURE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  always #5 clk = ~clk;

  // Inputs applied on the falling edge; expectation is the state after the next rising edge.
  task automatic step(input string nm, input logic rst, input logic [3:0] req,
                      input logic [3:0] lck, input logic [1:0] tr, input logic rdy,
                      input logic [3:0] g, input logic [1:0] m, input logic l);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hready  = rdy;
    e.g = g; e.m = m; e.l = l; e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (hgrant !== e.g || hmaster !== e.m || hmastlock !== e.l) begin
          miscompares++;
          $display("FAIL %s: got hgrant=%b hmaster=%0d hmastlock=%b, expected hgrant=%b hmaster=%0d hmastlock=%b",
                   e.name, hgrant, hmaster, hmastlock, e.g, e.m, e.l);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    // Reset with everyone requesting: parked on master 0
    step("reset0", 1, 4'b1111, 4'b0000, HTRANS_IDLE, 1, 4'b0001, 2'd0, 0);
    step("reset1", 1, 4'b1111, 4'b0000, HTRANS_IDLE, 1, 4'b0001, 2'd0, 0);
    // Round robin, hmaster one cycle behind
    step("rr_1", 0, 4'b1111, 4'b0000, HTRANS_IDLE, 1, 4'b0010, 2'd0, 0);
    step("rr_2", 0, 4'b1111, 4'b0000, HTRANS_IDLE, 1, 4'b0100, 2'd1, 0);
    step("rr_3", 0, 4'b1111, 4'b0000, HTRANS_IDLE, 1, 4'b1000, 2'd2, 0);
    step("rr_0", 0, 4'b1111, 4'b0000, HTRANS_IDLE, 1, 4'b0001, 2'd3, 0);
    step("rr_1b", 0, 4'b1111, 4'b0000, HTRANS_IDLE, 1, 4'b0010, 2'd0, 0);
    // Tenure: master 1 bursts, master 2 waits; counter hits 4 but SEQ is not broken
    step("ten_ns", 0, 4'b0110, 4'b0000, HTRANS_NONSEQ, 1, 4'b0010, 2'd1, 0);
    for (int i = 0; i < 5; i++)
      step("ten_seq", 0, 4'b0110, 4'b0000, HTRANS_SEQ, 1, 4'b0010, 2'd1, 0);
    step("ten_switch", 0, 4'b0110, 4'b0000, HTRANS_NONSEQ, 1, 4'b0100, 2'd1, 0);
    step("own2", 0, 4'b0100, 4'b0000, HTRANS_NONSEQ, 1, 4'b0100, 2'd2, 0);
    // Wait states: owner drops while master 3 asks, but hready low freezes everything
    for (int i = 0; i < 5; i++)
      step("wait_freeze", 0, 4'b1000, 4'b0000, HTRANS_NONSEQ, 0, 4'b0100, 2'd2, 0);
    step("wait_switch", 0, 4'b1000, 4'b0000, HTRANS_NONSEQ, 1, 4'b1000, 2'd2, 0);
    step("own3", 0, 4'b1000, 4'b0000, HTRANS_NONSEQ, 1, 4'b1000, 2'd3, 0);
    // Lock: master 3 keeps the bus despite expired tenure
    for (int i = 0; i < 40; i++)
      step("lock_hold", 0, 4'b1111, 4'b1000, HTRANS_NONSEQ, 1, 4'b1000, 2'd3, 1);
    step("unlock_sw", 0, 4'b1111, 4'b0000, HTRANS_NONSEQ, 1, 4'b0001, 2'd3, 0);
    step("own0", 0, 4'b1111, 4'b0000, HTRANS_NONSEQ, 1, 4'b0001, 2'd0, 0);
    // Park: master 2 takes over, then all requests drop
    step("to2", 0, 4'b0100, 4'b0000, HTRANS_IDLE, 1, 4'b0100, 2'd0, 0);
    step("park", 0, 4'b0000, 4'b0000, HTRANS_IDLE, 1, 4'b0001, 2'd2, 0);
    step("park_m", 0, 4'b0000, 4'b0000, HTRANS_IDLE, 1, 4'b0001, 2'd0, 0);
    // Reset in the middle of a locked transfer
    step("to1", 0, 4'b0010, 4'b0000, HTRANS_IDLE, 1, 4'b0010, 2'd0, 0);
    step("lock1", 0, 4'b0010, 4'b0010, HTRANS_NONSEQ, 1, 4'b0010, 2'd1, 1);
    step("reset_mid", 1, 4'b0010, 4'b0010, HTRANS_NONSEQ, 1, 4'b0001, 2'd0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
